// File: rtl/address_clock_seq.sv
// Address/clock block between the port logic and the bitcell array decoders: captures port
// enables/addresses, predecodes them into strobe-gated one-hot groups and sequences the strobe.
module address_clock_seq #(
    parameter int NRD     = 2,
    parameter int NWR     = 1,
    parameter int AW      = 6,
    parameter int GENMODE = 0,
    parameter int DW      = 4,
    localparam int PDW    = 2 + 4 * ((AW - 1) / 2) + 2 * ((AW - 1) % 2)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    output logic               ready,
    input  logic [NRD-1:0]     rd_enb,
    input  logic [NRD*AW-1:0]  rd_adr,
    input  logic [NWR-1:0]     wr_enb,
    input  logic [NWR*AW-1:0]  wr_adr,
    input  logic [DW-1:0]      cfg_dly,
    input  logic [DW-1:0]      cfg_wid,
    output logic               strobe,
    output logic [NRD*PDW-1:0] rd_pd,
    output logic [NWR*PDW-1:0] wr_pd,
    output logic               done,
    output logic               coll
);
    localparam int             NPAIR    = (AW - 1) / 2;
    localparam bit             HAS_TAIL = ((AW - 1) % 2) != 0;
    localparam logic [PDW-1:0] PD_ONE   = PDW'(1);

    // Line order per port, LSB first: na0, a0; then for each pair (a[k], a[k+1])
    // na_na, na_a, a_na, a_a with a[k] as the first letter; then na, a for a leftover top bit.
    function automatic logic [PDW-1:0] predecode(input logic [AW-1:0] a);
        logic [PDW-1:0] pd;
        logic [AW-1:0]  s;
        int             idx;
        pd = PD_ONE << int'(a[0]);
        for (int g = 0; g < NPAIR; g++) begin
            s   = a >> (1 + 2 * g);
            idx = 2 + 4 * g + 2 * int'(s[0]) + int'(s[1]);
            pd  = pd | (PD_ONE << idx);
        end
        if (HAS_TAIL) begin
            pd = pd | (PD_ONE << (PDW - 2 + int'(a[AW-1])));
        end
        return pd;
    endfunction

    logic              capture;
    logic              coll_d;
    logic              coll_clr;
    logic [NRD-1:0]    rd_enb_q;
    logic [NRD*AW-1:0] rd_adr_q;
    logic [NWR-1:0]    wr_enb_q;
    logic [NWR*AW-1:0] wr_adr_q;
    logic              coll_q;
    logic [NRD*NWR-1:0] match;

    assign capture = req && ready;

    for (genvar r = 0; r < NRD; r++) begin : g_match_rd
        for (genvar w = 0; w < NWR; w++) begin : g_match_wr
            assign match[r*NWR + w] = rd_enb[r] && wr_enb[w] &&
                                      (rd_adr[r*AW +: AW] == wr_adr[w*AW +: AW]);
        end
    end
    assign coll_d = |match;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            rd_enb_q <= '0;
            rd_adr_q <= '0;
            wr_enb_q <= '0;
            wr_adr_q <= '0;
            coll_q   <= 1'b0;
        end else if (capture) begin
            rd_enb_q <= rd_enb;
            rd_adr_q <= rd_adr;
            wr_enb_q <= wr_enb;
            wr_adr_q <= wr_adr;
            coll_q   <= coll_d;
        end else if (coll_clr) begin
            coll_q   <= 1'b0;
        end
    end

    assign coll = coll_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd_pd
        assign rd_pd[p*PDW +: PDW] = (rd_enb_q[p] && strobe) ? predecode(rd_adr_q[p*AW +: AW]) : '0;
    end
    for (genvar p = 0; p < NWR; p++) begin : g_wr_pd
        assign wr_pd[p*PDW +: PDW] = (wr_enb_q[p] && strobe) ? predecode(wr_adr_q[p*AW +: AW]) : '0;
    end

    if (GENMODE == 0) begin : g_nodelay
        logic strobe_q;
        logic unused_cfg;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                strobe_q <= 1'b0;
            end else begin
                strobe_q <= req;
            end
        end

        assign ready      = 1'b1;
        assign strobe     = strobe_q;
        assign done       = strobe_q;
        assign coll_clr   = 1'b0;
        assign unused_cfg = ^{cfg_dly, cfg_wid};
    end else begin : g_delay
        typedef enum logic [1:0] {IDLE, SETUP, STRB, HOLD} state_t;

        state_t        state_q, state_d;
        logic [DW-1:0] cnt_q, cnt_d;
        logic [DW-1:0] wid_q;
        logic [DW-1:0] wid_in;

        // A zero width still produces a one-cycle strobe.
        assign wid_in = (cfg_wid == '0) ? DW'(1) : cfg_wid;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                wid_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (capture) begin
                    wid_q <= wid_in;
                end
            end
        end

        always_comb begin
            // NOTE: every output gets a default first so no path through the case infers a latch.
            state_d = state_q;
            cnt_d   = cnt_q;
            ready   = 1'b0;
            strobe  = 1'b0;
            done    = 1'b0;
            case (state_q)
                IDLE: begin
                    ready = 1'b1;
                    if (req) begin
                        if (cfg_dly == '0) begin
                            state_d = STRB;
                            cnt_d   = wid_in;
                        end else begin
                            state_d = SETUP;
                            cnt_d   = cfg_dly;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q <= DW'(1)) begin
                        state_d = STRB;
                        cnt_d   = wid_q;
                    end else begin
                        cnt_d   = cnt_q - DW'(1);
                    end
                end
                STRB: begin
                    strobe = 1'b1;
                    if (cnt_q <= DW'(1)) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d   = cnt_q - DW'(1);
                    end
                end
                HOLD: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        assign coll_clr = (state_q == HOLD);
    end

endmodule

// File: tb/tb_address_clock_seq.sv
// Bench for address_clock_seq: a NoDelay 2r1w/AW=6 instance and a Delay 3r2w/AW=7 instance,
// directed scenarios followed by a random request stream against an access-timeline model.
module tb_address_clock_seq;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        nd_req, nd_ready, nd_strobe, nd_done, nd_coll;
    logic [1:0]  nd_rd_enb;
    logic [11:0] nd_rd_adr;
    logic [0:0]  nd_wr_enb;
    logic [5:0]  nd_wr_adr;
    logic [3:0]  nd_cfg_dly, nd_cfg_wid;
    logic [23:0] nd_rd_pd;
    logic [11:0] nd_wr_pd;

    logic        dl_req, dl_ready, dl_strobe, dl_done, dl_coll;
    logic [2:0]  dl_rd_enb;
    logic [20:0] dl_rd_adr;
    logic [1:0]  dl_wr_enb;
    logic [13:0] dl_wr_adr;
    logic [3:0]  dl_cfg_dly, dl_cfg_wid;
    logic [41:0] dl_rd_pd;
    logic [27:0] dl_wr_pd;

    address_clock_seq #(.NRD(2), .NWR(1), .AW(6), .GENMODE(0), .DW(DW)) u_nd (
        .clk(clk), .reset_n(reset_n), .req(nd_req), .ready(nd_ready),
        .rd_enb(nd_rd_enb), .rd_adr(nd_rd_adr), .wr_enb(nd_wr_enb), .wr_adr(nd_wr_adr),
        .cfg_dly(nd_cfg_dly), .cfg_wid(nd_cfg_wid), .strobe(nd_strobe),
        .rd_pd(nd_rd_pd), .wr_pd(nd_wr_pd), .done(nd_done), .coll(nd_coll)
    );

    address_clock_seq #(.NRD(3), .NWR(2), .AW(7), .GENMODE(1), .DW(DW)) u_dl (
        .clk(clk), .reset_n(reset_n), .req(dl_req), .ready(dl_ready),
        .rd_enb(dl_rd_enb), .rd_adr(dl_rd_adr), .wr_enb(dl_wr_enb), .wr_adr(dl_wr_adr),
        .cfg_dly(dl_cfg_dly), .cfg_wid(dl_cfg_wid), .strobe(dl_strobe),
        .rd_pd(dl_rd_pd), .wr_pd(dl_wr_pd), .done(dl_done), .coll(dl_coll)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected lines of one enabled port, evaluated line by line from the group rules.
    function automatic logic [13:0] exp_pd_port(input int aw, input int a);
        int          pdw   = 2 + 4 * ((aw - 1) / 2) + 2 * ((aw - 1) % 2);
        int          npair = (aw - 1) / 2;
        logic [13:0] v     = '0;
        for (int l = 0; l < pdw; l++) begin
            bit on;
            if (l < 2) begin
                on = ((a & 1) == l);
            end else if (l < 2 + 4 * npair) begin
                int g   = (l - 2) / 4;
                int pos = (l - 2) % 4;
                on = (((a >> (1 + 2 * g)) & 1) == pos / 2) && (((a >> (2 + 2 * g)) & 1) == pos % 2);
            end else begin
                on = (((a >> (aw - 1)) & 1) == l - (pdw - 2));
            end
            if (on) v = v | (14'd1 << l);
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_pd_all(input int np, input int aw, input logic [63:0] enb,
                                               input logic [63:0] adr, input bit stb);
        int          pdw  = 2 + 4 * ((aw - 1) / 2) + 2 * ((aw - 1) % 2);
        logic [63:0] mask = (64'd1 << aw) - 64'd1;
        logic [63:0] v    = '0;
        if (stb) begin
            for (int p = 0; p < np; p++) begin
                if (((enb >> p) & 64'd1) != 0)
                    v = v | (64'(exp_pd_port(aw, int'((adr >> (p * aw)) & mask))) << (p * pdw));
            end
        end
        return v;
    endfunction

    function automatic bit coll_of(input int nrd, input int nwr, input int aw,
                                   input logic [63:0] re, input logic [63:0] ra,
                                   input logic [63:0] we, input logic [63:0] wa);
        logic [63:0] mask = (64'd1 << aw) - 64'd1;
        for (int r = 0; r < nrd; r++)
            for (int w = 0; w < nwr; w++)
                if ((((re >> r) & 64'd1) != 0) && (((we >> w) & 64'd1) != 0) &&
                    (((ra >> (r * aw)) & mask) == ((wa >> (w * aw)) & mask)))
                    return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rnd_adr(input int aw);
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 3));
        return int'($urandom_range(0, (1 << aw) - 1));
    endfunction

    // Reference state: NoDelay is "what was accepted last edge"; Delay is a timeline t since capture.
    bit          m_nd_stb, m_nd_coll;
    logic [1:0]  m_nd_rd_enb;
    logic [11:0] m_nd_rd_adr;
    logic [0:0]  m_nd_wr_enb;
    logic [5:0]  m_nd_wr_adr;
    bit          m_busy, m_dl_coll;
    int          m_t, m_dly, m_wid;
    logic [2:0]  m_dl_rd_enb;
    logic [20:0] m_dl_rd_adr;
    logic [1:0]  m_dl_wr_enb;
    logic [13:0] m_dl_wr_adr;

    task automatic model_edge();
        if (!reset_n) begin
            m_nd_stb = 0; m_nd_coll = 0;
            m_nd_rd_enb = '0; m_nd_rd_adr = '0; m_nd_wr_enb = '0; m_nd_wr_adr = '0;
            m_busy = 0; m_t = 0; m_dl_coll = 0;
            m_dl_rd_enb = '0; m_dl_rd_adr = '0; m_dl_wr_enb = '0; m_dl_wr_adr = '0;
            return;
        end
        m_nd_stb = nd_req;
        if (nd_req) begin
            m_nd_rd_enb = nd_rd_enb; m_nd_rd_adr = nd_rd_adr;
            m_nd_wr_enb = nd_wr_enb; m_nd_wr_adr = nd_wr_adr;
            m_nd_coll = coll_of(2, 1, 6, 64'(nd_rd_enb), 64'(nd_rd_adr), 64'(nd_wr_enb), 64'(nd_wr_adr));
        end
        if (!m_busy) begin
            if (dl_req) begin
                m_busy = 1; m_t = 1;
                m_dly = int'(dl_cfg_dly);
                m_wid = (dl_cfg_wid == 0) ? 1 : int'(dl_cfg_wid);
                m_dl_rd_enb = dl_rd_enb; m_dl_rd_adr = dl_rd_adr;
                m_dl_wr_enb = dl_wr_enb; m_dl_wr_adr = dl_wr_adr;
                m_dl_coll = coll_of(3, 2, 7, 64'(dl_rd_enb), 64'(dl_rd_adr), 64'(dl_wr_enb), 64'(dl_wr_adr));
            end
        end else begin
            m_t++;
            if (m_t == m_dly + m_wid + 2) begin
                m_busy = 0; m_dl_coll = 0;
            end
        end
    endtask

    task automatic check_nd();
        check("nd_ready",  64'(nd_ready),  64'd1);
        check("nd_strobe", 64'(nd_strobe), 64'(m_nd_stb));
        check("nd_done",   64'(nd_done),   64'(m_nd_stb));
        check("nd_coll",   64'(nd_coll),   64'(m_nd_coll));
        check("nd_rd_pd",  64'(nd_rd_pd),  exp_pd_all(2, 6, 64'(m_nd_rd_enb), 64'(m_nd_rd_adr), m_nd_stb));
        check("nd_wr_pd",  64'(nd_wr_pd),  exp_pd_all(1, 6, 64'(m_nd_wr_enb), 64'(m_nd_wr_adr), m_nd_stb));
    endtask

    task automatic check_dl();
        bit e_stb  = m_busy && (m_t > m_dly) && (m_t <= m_dly + m_wid);
        bit e_done = m_busy && (m_t == m_dly + m_wid + 1);
        check("dl_ready",  64'(dl_ready),  64'(!m_busy));
        check("dl_strobe", 64'(dl_strobe), 64'(e_stb));
        check("dl_done",   64'(dl_done),   64'(e_done));
        check("dl_coll",   64'(dl_coll),   64'(m_dl_coll));
        check("dl_rd_pd",  64'(dl_rd_pd),  exp_pd_all(3, 7, 64'(m_dl_rd_enb), 64'(m_dl_rd_adr), e_stb));
        check("dl_wr_pd",  64'(dl_wr_pd),  exp_pd_all(2, 7, 64'(m_dl_wr_enb), 64'(m_dl_wr_adr), e_stb));
        for (int p = 0; p < 3; p++)
            check($sformatf("dl_rd_lines%0d", p), 64'($countones(dl_rd_pd[p*14 +: 14])),
                  (e_stb && m_dl_rd_enb[p]) ? 64'd4 : 64'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_nd();
        check_dl();
    endtask

    logic [6:0] s_obs, d_obs, r_obs;
    bit         done_seen;

    initial begin
        reset_n = 1'b0;
        nd_req = 0; nd_rd_enb = '0; nd_rd_adr = '0; nd_wr_enb = '0; nd_wr_adr = '0;
        nd_cfg_dly = '0; nd_cfg_wid = '0;
        dl_req = 0; dl_rd_enb = '0; dl_rd_adr = '0; dl_wr_enb = '0; dl_wr_adr = '0;
        dl_cfg_dly = '0; dl_cfg_wid = '0;
        tick();
        tick();
        check("rst_dl_ready", 64'(dl_ready), 64'd1);
        reset_n = 1'b1;
        tick();

        // NoDelay predecode of 6'b101101 on read port 0.
        nd_req = 1; nd_rd_enb = 2'b01; nd_rd_adr = {6'd0, 6'b101101};
        tick();
        check("t1_strobe", 64'(nd_strobe), 64'd1);
        check("t1_pd", 64'(nd_rd_pd), 64'h90A);
        nd_req = 0;
        tick();
        check("t1_idle", 64'(nd_strobe), 64'd0);

        // NoDelay collision: rd1 vs wr0 at 17, then rd1 disabled.
        nd_req = 1; nd_rd_enb = 2'b10; nd_rd_adr = {6'd17, 6'd3}; nd_wr_enb = 1'b1; nd_wr_adr = 6'd17;
        tick();
        check("t4_nd_coll", 64'(nd_coll), 64'd1);
        nd_rd_enb = 2'b00;
        tick();
        check("t4_nd_nocoll", 64'(nd_coll), 64'd0);
        nd_req = 0;
        tick();

        // Delay mode, dly=2 wid=3: timeline over the 7 cycles after capture.
        dl_cfg_dly = 4'd2; dl_cfg_wid = 4'd3; dl_rd_enb = 3'b001; dl_rd_adr = 21'h5A; dl_req = 1;
        tick();
        dl_req = 0; dl_cfg_dly = 4'd9; dl_cfg_wid = 4'd9;
        for (int k = 0; k < 7; k++) begin
            s_obs[k] = dl_strobe; d_obs[k] = dl_done; r_obs[k] = dl_ready;
            tick();
        end
        check("t2_strobe", 64'(s_obs), 64'b0011100);
        check("t2_done",   64'(d_obs), 64'b0100000);
        check("t2_ready",  64'(r_obs), 64'b1000000);

        // Delay mode, dly=0 wid=0 with req held high across two accesses.
        dl_cfg_dly = 4'd0; dl_cfg_wid = 4'd0; dl_req = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            s_obs[k] = dl_strobe; d_obs[k] = dl_done; r_obs[k] = dl_ready;
            tick();
        end
        check("t3_strobe", 64'(s_obs[5:0]), 64'b001001);
        check("t3_done",   64'(d_obs[5:0]), 64'b010010);
        check("t3_ready",  64'(r_obs[5:0]), 64'b100100);
        dl_req = 0;
        repeat (4) tick();

        // Delay mode collision and its clearing on return to idle.
        dl_cfg_dly = 4'd0; dl_cfg_wid = 4'd1;
        dl_rd_enb = 3'b010; dl_rd_adr = {7'd0, 7'd17, 7'd0}; dl_wr_enb = 2'b01; dl_wr_adr = {7'd5, 7'd17};
        dl_req = 1;
        tick();
        check("t4_dl_coll", 64'(dl_coll), 64'd1);
        dl_req = 0;
        tick();
        tick();
        check("t4_dl_clear", 64'(dl_coll), 64'd0);
        dl_rd_enb = 3'b000; dl_req = 1;
        tick();
        check("t4_dl_nocoll", 64'(dl_coll), 64'd0);
        dl_req = 0;
        repeat (3) tick();

        // Reset in the middle of the strobe.
        dl_cfg_dly = 4'd1; dl_cfg_wid = 4'd4; dl_rd_enb = 3'b111; dl_req = 1;
        tick();
        dl_req = 0;
        tick();
        check("t5_in_strb", 64'(dl_strobe), 64'd1);
        reset_n = 1'b0;
        tick();
        check("t5_strobe", 64'(dl_strobe), 64'd0);
        check("t5_pd", 64'({dl_rd_pd, dl_wr_pd}), 64'd0);
        check("t5_ready", 64'(dl_ready), 64'd1);
        reset_n = 1'b1;
        done_seen = dl_done;
        repeat (6) begin
            tick();
            done_seen = done_seen | dl_done;
        end
        check("t5_no_done", 64'(done_seen), 64'd0);

        // Random stream on both instances, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset_n    = ($urandom_range(0, 99) != 0);
            nd_req     = ($urandom_range(0, 3) != 0);
            nd_rd_enb  = 2'($urandom);
            nd_wr_enb  = 1'($urandom);
            nd_rd_adr  = {6'(rnd_adr(6)), 6'(rnd_adr(6))};
            nd_wr_adr  = 6'(rnd_adr(6));
            dl_req     = ($urandom_range(0, 2) != 0);
            dl_rd_enb  = 3'($urandom);
            dl_wr_enb  = 2'($urandom);
            dl_rd_adr  = {7'(rnd_adr(7)), 7'(rnd_adr(7)), 7'(rnd_adr(7))};
            dl_wr_adr  = {7'(rnd_adr(7)), 7'(rnd_adr(7))};
            dl_cfg_dly = 4'($urandom_range(0, 3));
            dl_cfg_wid = 4'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
